// File: rtl/message_scroller.sv
// Circular 4-bit character message with a registered 4-entry display window.
// Optional macro SCROLL_REVERSE_EN adds a dir input for backward scrolling.
module message_scroller #(
  parameter int MSG_LEN      = 16,
  parameter int SCROLL_TICKS = 5000000,
  parameter int PTR_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             step,
  input  logic             auto_en,
`ifdef SCROLL_REVERSE_EN
  input  logic             dir,
`endif
  output logic [15:0]      digits,
  output logic [PTR_W-1:0] ptr,
  output logic             advance
);

  localparam int CNT_W = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(SCROLL_TICKS - 1);

  logic [3:0]       mem_q [MSG_LEN];
  logic [3:0]       mem_d [MSG_LEN];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [15:0]      digits_q, digits_d;
  logic             adv_q, adv_d;
  logic             tick;

  always_comb begin
    tick  = auto_en && (cnt_q == TC);
    adv_d = tick || step;

    // any advance, manual or automatic, restarts the interval
    cnt_d = cnt_q + CNT_W'(1);
    if (!auto_en || adv_d) cnt_d = '0;

    ptr_d = ptr_q;
    if (adv_d) begin
`ifdef SCROLL_REVERSE_EN
      ptr_d = dir ? (ptr_q - PTR_W'(1)) : (ptr_q + PTR_W'(1));
`else
      ptr_d = ptr_q + PTR_W'(1);
`endif
    end

    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;

    digits_d = '0;
    for (int k = 0; k < 4; k++) begin
      digits_d[15-4*k -: 4] = mem_q[ptr_q + PTR_W'(k)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= 4'(i % 16);
      cnt_q    <= '0;
      ptr_q    <= '0;
      digits_q <= 16'h0123;
      adv_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      digits_q <= digits_d;
      adv_q    <= adv_d;
    end
  end

  assign digits  = digits_q;
  assign ptr     = ptr_q;
  assign advance = adv_q;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: directed steps then random traffic against a queue-free array model.
module tb_message_scroller;
  localparam int MSG_LEN = 16;
  localparam int TICKS   = 4;
  localparam int PTR_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [PTR_W-1:0] wr_addr = '0;
  logic [3:0]       wr_data = '0;
  logic             step = 1'b0;
  logic             auto_en = 1'b0;
  logic             dir = 1'b0;
  logic [15:0]      digits;
  logic [PTR_W-1:0] ptr;
  logic             advance;

  int n_cmp = 0;
  int n_err = 0;

  int m_mem [MSG_LEN];
  int m_ptr, m_since;
  logic [15:0] m_digits;
  logic m_adv;

  message_scroller #(.MSG_LEN(MSG_LEN), .SCROLL_TICKS(TICKS), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step(step), .auto_en(auto_en),
`ifdef SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .digits(digits), .ptr(ptr), .advance(advance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] window(input int p);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[15-4*k -: 4] = 4'(m_mem[(p + k) % MSG_LEN]);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) m_mem[i] = i % 16;
    m_ptr = 0; m_since = 0; m_adv = 1'b0; m_digits = 16'h0123;
  endtask

  // one clock: advance the model from the inputs present at the edge, then compare
  task automatic cycle();
    logic go;
    @(posedge clk);
    go = (auto_en && m_since == TICKS - 1) || step;
    m_digits = window(m_ptr);
    if (wr_en) m_mem[wr_addr] = int'(wr_data);
    if (go) begin
`ifdef SCROLL_REVERSE_EN
      m_ptr = dir ? (m_ptr + MSG_LEN - 1) % MSG_LEN : (m_ptr + 1) % MSG_LEN;
`else
      m_ptr = (m_ptr + 1) % MSG_LEN;
`endif
    end
    m_since = (!auto_en || go) ? 0 : m_since + 1;
    m_adv = go;
    #1;
    chk("digits", digits, m_digits);
    chk("ptr", 16'(ptr), 16'(m_ptr));
    chk("advance", 16'(advance), 16'(m_adv));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    auto_en = 1'b0; step = 1'b0; wr_en = 1'b0; dir = 1'b0;
    model_reset();
    #12;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #23;
    reset = 1'b1;
    chk("rst_digits", digits, 16'h0123);
    chk("rst_ptr", 16'(ptr), 16'h0000);
    chk("rst_adv", 16'(advance), 16'h0000);

    // idle: nothing moves
    for (int i = 0; i < 20; i++) cycle();
    chk("idle_digits", digits, 16'h0123);

    // auto scroll from reset
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("auto_no_early", 16'(advance), 16'h0000);
    cycle();
    chk("auto_first_adv", 16'(advance), 16'h0001);
    chk("auto_ptr1", 16'(ptr), 16'h0001);
    cycle();
    chk("auto_dig1234", digits, 16'h1234);
    for (int i = 0; i < 14 * TICKS; i++) cycle();
    chk("auto_ptr15", 16'(ptr), 16'h000F);
    cycle();
    chk("auto_digF012", digits, 16'hF012);
    for (int i = 0; i < TICKS; i++) cycle();
    chk("auto_wrap_ptr", 16'(ptr), 16'h0000);
    cycle();
    chk("auto_wrap_dig", digits, 16'h0123);

    // manual back-to-back steps
    do_reset();
    for (int i = 0; i < 9; i++) cycle();
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("step_ptr", 16'(ptr), 16'(i + 1));
    end
    step = 1'b0;
    cycle();
    chk("step_dig3456", digits, 16'h3456);

    // step coinciding with a tick, then exactly TICKS to the next advance
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < TICKS - 1; i++) cycle();
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("coinc_ptr", 16'(ptr), 16'h0001);
    for (int i = 0; i < TICKS - 1; i++) begin
      cycle();
      chk("coinc_gap", 16'(advance), 16'h0000);
    end
    cycle();
    chk("coinc_next", 16'(advance), 16'h0001);

    // writes in and out of the window at ptr=2
    do_reset();
    step = 1'b1;
    cycle(); cycle();
    step = 1'b0;
    cycle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'hA;
    cycle();
    wr_addr = 4'd9; wr_data = 4'hE;
    cycle();
    wr_en = 1'b0;
    chk("wr_in_window", digits, 16'h2A45);
    cycle();
    chk("wr_out_window", digits, 16'h2A45);

    // asynchronous reset mid-scroll at ptr=7
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 7 * TICKS; i++) cycle();
    chk("mid_ptr7", 16'(ptr), 16'h0007);
    #3;
    reset = 1'b0;
    #1;
    chk("async_ptr", 16'(ptr), 16'h0000);
    chk("async_digits", digits, 16'h0123);
    model_reset();
    @(negedge clk);
    auto_en = 1'b0;
    #2;
    reset = 1'b1;

`ifdef SCROLL_REVERSE_EN
    dir = 1'b1; step = 1'b1;
    cycle();
    step = 1'b0;
    chk("rev_ptr15", 16'(ptr), 16'h000F);
    cycle();
    chk("rev_digF012", digits, 16'hF012);
    dir = 1'b0;
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      auto_en = ($urandom_range(0, 3) != 0);
      step    = ($urandom_range(0, 4) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = PTR_W'($urandom_range(0, MSG_LEN - 1));
      wr_data = 4'($urandom_range(0, 15));
      dir     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/message_scroller.md
Name: message_scroller

Overview:
- Upstream feeder for the four-digit seven-segment display path.
- Holds a writable circular message of 4-bit character codes and presents a 4-character window, one code per digit, to the digit driver/decoder.
- Advances the window automatically on a programmable tick count, or on a single-cycle step pulse from the cleaned push-button.
- Runs in the display clock domain.

Parameters:
MSG_LEN, 16, number of message entries; power of two, minimum 4
SCROLL_TICKS, 5000000, clk cycles per automatic advance; minimum 2
PTR_W, 4, pointer/address width, equal to log2(MSG_LEN)

Ports:
clk  input  1  display clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
wr_en  input  1  write strobe for message memory
wr_addr  input  PTR_W  write address
wr_data  input  4  character code to write
step  input  1  single-cycle advance request (from debounced button)
auto_en  input  1  1 = automatic scrolling enabled
digits  output  16  window: [15:12] leftmost (an3) ... [3:0] rightmost (an0)
ptr  output  PTR_W  index of the leftmost displayed entry
advance  output  1  one-cycle pulse in the cycle ptr changes

Behaviour:
- Reset (reset=0, asynchronous):
  - ptr=0, tick counter=0, advance=0.
  - mem[i] = i mod 16.
  - digits = {mem[0],mem[1],mem[2],mem[3]} = 16'h0123.
- Release is synchronous in effect: the first update happens at the first clk edge with reset=1.
- Window:
  - digits is registered, recomputed every cycle from {mem[ptr],mem[ptr+1],mem[ptr+2],mem[ptr+3]}.
  - Indices wrap modulo MSG_LEN.
  - Latency: one cycle after any ptr or mem update.
- Tick counter:
  - When auto_en=1, increments each cycle.
  - On reaching SCROLL_TICKS-1 it returns to 0 and raises an internal tick.
  - When auto_en=0 the counter is cleared to 0 and held.
- Advance event = tick OR step.
  - On an advance, ptr <= (ptr+1) mod MSG_LEN.
  - advance=1 is registered in the same edge as the ptr update, so it is visible for the cycle in which the new ptr is valid.
- tick and step in the same cycle: ptr advances by exactly one; one advance pulse.
- step in any cycle that is not a tick: the counter is restarted to 0, so the next auto advance comes a full SCROLL_TICKS later.
- step while auto_en=0: ptr still advances (manual mode).
- Back-to-back step on consecutive cycles: one advance each cycle.
- Wrap: ptr=MSG_LEN-1 advances to 0. Window at ptr=MSG_LEN-1 is {mem[15],mem[0],mem[1],mem[2]} for the default.
- Writes:
  - When wr_en=1, mem[wr_addr] <= wr_data at the clock edge.
  - Write and advance in the same cycle: both take effect; digits on the following cycle reflect the new data at the new ptr.
  - A write to an entry not in the window has no visible effect on digits.
- Reset mid-scroll: all state returns to reset values immediately, including mem contents.
- No other outputs toggle while auto_en=0 and step=0 and wr_en=0; digits is stable.

Optional Feature:
SCROLL_REVERSE_EN
- Defined:
  - Adds input port dir (1 bit).
  - An advance with dir=1 sets ptr <= (ptr-1) mod MSG_LEN; ptr=0 wraps to MSG_LEN-1. dir=0 increments as normal.
  - dir is sampled in the advance cycle; a dir change alone causes no advance.
- Not defined:
  - No dir port.
  - ptr only increments; all other behaviour is identical.

Test Plan:
- Reset, SCROLL_TICKS=4, auto_en=0, no step for 20 cycles -> digits=16'h0123, ptr=0, advance never 1.
- auto_en=1 from reset release -> first advance pulse after 4 cycles, ptr=1, digits=16'h1234 one cycle later; after 16 advances ptr=0 and digits=16'h0123. At ptr=15, digits=16'hF012.
- auto_en=0, step pulses at cycles 10, 11, 12 -> ptr 1, 2, 3 on consecutive cycles; digits=16'h3456.
- auto_en=1, step asserted in the same cycle as a tick -> ptr advances by one only; next advance arrives exactly 4 cycles later.
- At ptr=2, write wr_addr=3, wr_data=4'hA -> next cycle digits=16'h2A45. Write to addr 9 -> digits unchanged.
- Assert reset=0 mid-scroll at ptr=7 with auto_en=1 -> ptr=0 and digits=16'h0123 immediately (asynchronously). With SCROLL_REVERSE_EN, dir=1 and a step from ptr=0 -> ptr=15, digits=16'hF012.
